// File: rtl/md_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// Operation codes and FSM state codes used by md_unit and its bench.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic int unsigned md_max(int unsigned x, int unsigned y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX <-> multiply/divide unit bundle; flush exists only with MD_FLUSH_EN.
// master = EX/hazard side, slave = md_unit.
interface md_unit_if;

    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MD_FLUSH_EN
    logic        flush;
`endif

    modport master (
        output start, md_op, a, b,
`ifdef MD_FLUSH_EN
        output flush,
`endif
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, md_op, a, b,
`ifdef MD_FLUSH_EN
        input  flush,
`endif
        output busy, stall_md, hi, lo
    );

endinterface

// File: rtl/md_unit_div_core.sv
// Combinational signed/unsigned 32-bit divider for md_unit.
// Works on magnitudes so 0x80000000 / -1 yields 0x80000000 rem 0.
module md_div_core (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sgn_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o,
    output logic        div_zero_o
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    assign a_neg      = sgn_i & a_i[31];
    assign b_neg      = sgn_i & b_i[31];
    assign a_mag      = a_neg ? (32'd0 - a_i) : a_i;
    assign b_mag      = b_neg ? (32'd0 - b_i) : b_i;
    assign div_zero_o = (b_i == 32'd0);

    always_comb begin
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (!div_zero_o) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend.
    assign quo_o = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem_o = a_neg ? (32'd0 - r_mag) : r_mag;

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit with HI/LO and a latency-window busy counter.
// Optional MD_FLUSH_EN adds a flush input that aborts an in-flight op.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    md_unit_if.slave   bus
);

    localparam int unsigned CNT_W =
        $clog2(md_max(MULT_CYCLES, DIV_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hip_q, hip_d;
    logic [31:0]      lop_q, lop_d;

    logic        is_mul;
    logic        is_div;
    logic        is_mthi;
    logic        is_mtlo;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_zero;

    assign is_mul  = bus.start & ((bus.md_op == MD_MULT) |
                                  (bus.md_op == MD_MULTU));
    assign is_div  = bus.start & ((bus.md_op == MD_DIV) |
                                  (bus.md_op == MD_DIVU));
    assign is_mthi = bus.start & (bus.md_op == MD_MTHI);
    assign is_mtlo = bus.start & (bus.md_op == MD_MTLO);

    assign prod_s = $signed({{32{bus.a[31]}}, bus.a}) *
                    $signed({{32{bus.b[31]}}, bus.b});
    assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

    md_div_core u_div (
        .a_i        (bus.a),
        .b_i        (bus.b),
        .sgn_i      (bus.md_op == MD_DIV),
        .quo_o      (quo),
        .rem_o      (rem),
        .div_zero_o (div_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hip_d   = hip_q;
        lop_d   = lop_q;
        unique case (state_q)
            MD_IDLE: begin
                unique case (1'b1)
                    is_mul: begin
                        {hip_d, lop_d} = (bus.md_op == MD_MULT) ?
                                         prod_s : prod_u;
                        cnt_d   = MULT_LAST;
                        state_d = MD_RUN;
                    end
                    is_div: begin
                        // Divide by zero commits the current HI/LO back.
                        hip_d   = div_zero ? hi_q : rem;
                        lop_d   = div_zero ? lo_q : quo;
                        cnt_d   = DIV_LAST;
                        state_d = MD_RUN;
                    end
                    is_mthi: hi_d = bus.a;
                    is_mtlo: lo_d = bus.a;
                    default: ;
                endcase
            end
            MD_RUN: begin
                if (cnt_q == '0) begin
                    hi_d    = hip_q;
                    lo_d    = lop_q;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
`ifdef MD_FLUSH_EN
        if (bus.flush) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hip_q   <= 32'd0;
            lop_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hip_q   <= hip_d;
            lop_q   <= lop_d;
        end
    end

    assign bus.busy     = (state_q == MD_RUN);
    assign bus.stall_md = bus.start | bus.busy;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency windows, HI/LO results, reset abort.
// Exercises the flush path when MD_FLUSH_EN is defined.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk;
    logic reset_n;
    int   n_pass;
    int   n_total;

    md_unit_if bus ();

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The hazard unit must never issue while busy.
    always @(posedge clk)
        if (reset_n)
            assert (!(bus.start && bus.busy))
            else $error("start asserted while busy");

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    endtask

    task automatic run_op(input string tag,
                          input logic [2:0] op,
                          input logic [31:0] av,
                          input logic [31:0] bv,
                          input int n,
                          input logic [31:0] eh,
                          input logic [31:0] el);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.a     = av;
        bus.b     = bv;
        #1 chk({tag, " stall"}, 32'(bus.stall_md), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 64) begin
            cyc++;
            @(negedge clk);
        end
        chk({tag, " cycles"}, 32'(cyc), 32'(n));
        chk({tag, " hi"}, bus.hi, eh);
        chk({tag, " lo"}, bus.lo, el);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
`ifdef MD_FLUSH_EN
        bus.flush = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst stall", 32'(bus.stall_md), 32'd0);
        chk("rst hi", bus.hi, 32'd0);
        chk("rst lo", bus.lo, 32'd0);
        reset_n = 1'b1;

        run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult max*min", MD_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 5,
               32'hC000_0000, 32'h8000_0000);
        run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10,
               32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'h0000_0000, 32'h8000_0000);
        run_op("divu 100/7", MD_DIVU, 32'd100, 32'd7, 10,
               32'h0000_0002, 32'h0000_000E);
        run_op("divu big", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 10,
               32'h0000_0001, 32'h7FFF_FFFC);
        run_op("mthi", MD_MTHI, 32'h11, 32'd0, 0,
               32'h0000_0011, 32'h7FFF_FFFC);
        run_op("mtlo", MD_MTLO, 32'h22, 32'd0, 0,
               32'h0000_0011, 32'h0000_0022);
        run_op("divu by 0", MD_DIVU, 32'd1234, 32'd0, 10,
               32'h0000_0011, 32'h0000_0022);
        run_op("bad op", 3'd7, 32'd5, 32'd6, 0,
               32'h0000_0011, 32'h0000_0022);

`ifdef MD_FLUSH_EN
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = MD_MULT;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush busy", 32'(bus.busy), 32'd0);
        repeat (8) @(negedge clk);
        chk("flush hi", bus.hi, 32'h0000_0011);
        chk("flush lo", bus.lo, 32'h0000_0022);
`endif

        run_op("pre mthi", MD_MTHI, 32'h55, 32'd0, 0,
               32'h0000_0055, 32'h0000_0022);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = MD_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst hi", bus.hi, 32'd0);
        chk("midrst lo", bus.lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("postrst busy", 32'(bus.busy), 32'd0);
        chk("postrst hi", bus.hi, 32'd0);
        chk("postrst lo", bus.lo, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
